// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS fetch stage.
//   - OP_J / OP_JAL opcodes recognised by fetch for local redirection
//   - DEFAULT_RESET_PC used as the default reset program counter
//   - fetch_state_e, the two-state fetch FSM encoding
//   - pc_is_illegal(), the fetch-address legality test
package mips_pkg;

  localparam logic [5:0]  OP_J             = 6'h02;
  localparam logic [5:0]  OP_JAL           = 6'h03;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  // A PC is legal only when word aligned and inside instruction memory.
  // limit is the byte size of memory (4 * number of words).
  function automatic logic pc_is_illegal(input logic [31:0] pc, input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc >= limit);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: bus between the fetch stage, instruction memory
// and decode.
//   Address      fetch -> memory   word address (equals PC)
//   Instruction  memory -> fetch   instruction at Address, same cycle
//   Instr_out    fetch -> decode   registered instruction in IF/ID slot
//   PCPlus4_out  fetch -> decode   registered PC+4 of Instr_out
//   Valid_out    fetch -> decode   slot holds an instruction
//   Ready_in     decode -> fetch   decode accepts the slot this cycle
//   Redirect     decode -> fetch   taken branch / jr redirect
//   RedirectPC   decode -> fetch   redirect target
//   Fault        fetch -> system   sticky illegal fetch-address fault
interface instruction_fetch_if;

  logic [31:0] Address;
  logic [31:0] Instruction;
  logic [31:0] Instr_out;
  logic [31:0] PCPlus4_out;
  logic        Valid_out;
  logic        Ready_in;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Fault;

  // Fetch-stage side.
  modport master (
    output Address, Instr_out, PCPlus4_out, Valid_out, Fault,
    input  Instruction, Ready_in, Redirect, RedirectPC
  );

  // Memory / decode / system side.
  modport slave (
    input  Address, Instr_out, PCPlus4_out, Valid_out, Fault,
    output Instruction, Ready_in, Redirect, RedirectPC
  );

endinterface

// File: rtl/if_next_pc.sv
// if_next_pc: combinational next-PC computation for the fetch stage.
//   pc_i          current PC
//   instr_i       instruction fetched at pc_i
//   pc_plus4_o    pc_i + 4 (32-bit wrap)
//   jump_target_o J/JAL target {pc+4[31:28], instr[25:0], 2'b00}
//   is_jump_o     instr_i is J or JAL
//   illegal_o     the selected next PC is not a legal fetch address
module if_next_pc
  import mips_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] jump_target_o,
  output logic        is_jump_o,
  output logic        illegal_o
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) * 32'd4;

  logic [5:0]  opcode_s;
  logic [31:0] next_pc_s;

  assign opcode_s      = instr_i[31:26];
  assign pc_plus4_o    = pc_i + 32'd4;
  assign jump_target_o = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
  assign is_jump_o     = (opcode_s == OP_J) || (opcode_s == OP_JAL);
  assign next_pc_s     = is_jump_o ? jump_target_o : pc_plus4_o;
  assign illegal_o     = pc_is_illegal(next_pc_s, PC_LIMIT);

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage with a one-entry IF/ID slot.
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-low reset
//   bus    instruction_fetch_if.master: memory address/data, IF/ID slot
//          with valid/ready handshake, downstream redirect, sticky Fault
// J/JAL are followed locally so they cost no bubble; branches and jr come
// back as Redirect and cost one bubble. Any illegal next PC parks the
// stage in FAULT until reset.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          IMEM_WORDS = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_fetch_if.master  bus
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) * 32'd4;

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_plus4_q;
  logic         valid_q;
  logic         fault_q;

  logic [31:0]  pc_plus4_d;
  logic [31:0]  jump_target_d;
  logic         is_jump_d;
  logic         next_illegal_d;
  logic [31:0]  next_pc_d;
  logic         slot_free_d;
  logic         redirect_illegal_d;

  if_next_pc #(
    .IMEM_WORDS (IMEM_WORDS)
  ) u_next_pc (
    .pc_i          (pc_q),
    .instr_i       (bus.Instruction),
    .pc_plus4_o    (pc_plus4_d),
    .jump_target_o (jump_target_d),
    .is_jump_o     (is_jump_d),
    .illegal_o     (next_illegal_d)
  );

  assign next_pc_d          = is_jump_d ? jump_target_d : pc_plus4_d;
  // Decode taking the slot this cycle frees it for a new capture.
  assign slot_free_d        = !valid_q || bus.Ready_in;
  assign redirect_illegal_d = pc_is_illegal(bus.RedirectPC, PC_LIMIT);

  assign bus.Address     = pc_q;
  assign bus.Instr_out   = instr_q;
  assign bus.PCPlus4_out = pc_plus4_q;
  assign bus.Valid_out   = valid_q;
  assign bus.Fault       = fault_q;

  // Fetch FSM: PC, IF/ID slot, fault flag and state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      pc_plus4_q <= 32'h0000_0000;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.Redirect) begin
            // Flush the slot; a handshake completing this cycle has
            // already been consumed by decode, so nothing is lost.
            valid_q <= 1'b0;
            if (redirect_illegal_d) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q <= bus.RedirectPC;
            end
          end else if (slot_free_d) begin
            instr_q    <= bus.Instruction;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= 1'b1;
            // The instruction is still delivered; only the PC refuses
            // to advance to an illegal address.
            if (next_illegal_d) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q <= next_pc_d;
            end
          end else begin
            valid_q <= valid_q;
          end
        end
        ST_FAULT: begin
          // Let a pending slot drain; never refill, ignore Redirect.
          fault_q <= 1'b1;
          if (bus.Ready_in) begin
            valid_q <= 1'b0;
          end else begin
            valid_q <= valid_q;
          end
        end
        default: begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
